rand_arbiter: RTL and testbench
===============================

RAND_ARBITER -- requirements
Module: rand_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters; SHALL be a power of two, 2..16.
REQ-002 Parameter LFSR_BITS, default 4, width of internal LFSR; SHALL be 2..5.
REQ-003 Parameter STARVE_LIMIT, default 7, lost decisions before forced grant; SHALL be 1..15.
REQ-004 clock  input  1  clock; all state updates on posedge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 req  input  NUM_REQ  per-requester request level.
REQ-007 done  input  1  resource reports current transaction complete (one-cycle pulse).
REQ-008 gnt  output  NUM_REQ  one-hot grant, registered, held for the whole transaction.
REQ-009 gnt_idx  output  clog2(NUM_REQ)  binary index of gnt bit.
REQ-010 start  output  1  one-cycle pulse telling the resource a new transaction begins.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 starve_hit  output  1  pulses with start when the grant was forced by starvation.

Function
REQ-013 The FSM SHALL have states IDLE, START and WAIT.
REQ-014 IDLE with |req=1 SHALL be a decision cycle: winner registered into gnt/gnt_idx, next state START.
REQ-015 IDLE with req=0 SHALL stay IDLE with gnt=0; done in IDLE SHALL be ignored.
REQ-016 START SHALL assert start=1 for exactly one cycle; next state IDLE if done=1, else WAIT.
REQ-017 WAIT SHALL hold gnt/gnt_idx; on done=1 next state IDLE.
REQ-018 Latency: req sampled in decision cycle t -> gnt and start visible in cycle t+1.
REQ-019 Back-to-back: done in cycle t -> IDLE at t+1 (decision cycle) -> next start at t+2.
REQ-020 Changes on req during START/WAIT SHALL NOT affect gnt, including deassertion by the holder.
REQ-021 Normal selection: start index s = LFSR value mod NUM_REQ (zero-extended if LFSR_BITS < clog2(NUM_REQ)); scan s, s+1, ... wrapping mod NUM_REQ; first requester with req=1 wins.
REQ-022 The LFSR SHALL advance exactly once per decision cycle and SHALL hold otherwise; sequence uses taps bit0^bit(N-1) for 2..4 bits and bit1^bit4 for 5 bits, shift left, feedback into bit0.
REQ-023 Each requester SHALL own an age counter, width clog2(STARVE_LIMIT+1), saturating at STARVE_LIMIT.
REQ-024 On a decision, each requester with req=1 that loses SHALL increment its counter; the winner SHALL clear its counter.
REQ-025 In IDLE, a requester with req=0 SHALL clear its counter.
REQ-026 Forced selection: if any requester has req=1 and counter==STARVE_LIMIT, the lowest such index SHALL win regardless of LFSR, and starve_hit SHALL pulse with start.
REQ-027 gnt SHALL be one-hot or zero in every cycle; gnt_idx SHALL equal the set bit, 0 when gnt=0.

Reset
REQ-028 Reset SHALL force state IDLE, gnt=0, gnt_idx=0, start=0, busy=0, starve_hit=0, all counters 0, LFSR=1.
REQ-029 Reset asserted mid-transaction SHALL drop gnt at the next edge; no start SHALL follow until a fresh decision.

Structure
REQ-030 Package arb_pkg SHALL hold the arb_state_t enum (IDLE, START, WAIT).
REQ-031 The LFSR SHALL be the existing team LFSR module, instantiated with NUM_BITS=LFSR_BITS and enable = decision cycle.
REQ-032 Selection logic (rotate scan, starvation override) SHALL be combinational; outputs and counters registered.

Verification
REQ-033 Reset, NUM_REQ=4, LFSR_BITS=4, req=4'b1111 held -> first gnt=4'b0010 (LFSR=1), start=1 one cycle; after done, next gnt=4'b1000 (LFSR=4'b0011).
REQ-034 Single req=4'b0100 -> gnt=4'b0100 at t+1; done pulsed 3 cycles later -> busy low next cycle, gnt=0.
REQ-035 STARVE_LIMIT=2, req0 forced to lose two decisions -> third decision gnt=4'b0001 with starve_hit=1.
REQ-036 Holder drops req in WAIT -> gnt unchanged until done; done in IDLE with req=0 -> no state change.
REQ-037 Reset asserted in WAIT -> next cycle gnt=0, busy=0, LFSR=1; done in START -> IDLE next cycle, no WAIT entered.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the random arbiter slice.
// Holds the arbiter FSM state encoding, which the top-level controller uses.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,   // no transaction; a cycle with any request here is a decision cycle
        START,  // first cycle of a granted transaction, start pulses
        WAIT    // grant held until the resource reports done
    } arb_state_t;

endpackage

// File: rtl/rand_arbiter_if.sv
// Handshake bundle between the arbiter, its requesters and the shared resource.
//   req        : per-requester request level (requesters -> arbiter)
//   done       : one-cycle transaction-complete pulse (resource -> arbiter)
//   gnt        : one-hot registered grant, held for the whole transaction
//   gnt_idx    : binary index of the gnt bit, 0 when no grant
//   start      : one-cycle pulse marking the first cycle of a transaction
//   busy       : high while a transaction is open
//   starve_hit : pulses with start when the grant was forced by starvation
// Modport master is the arbiter's view; slave is the requester/resource view.
interface rand_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic               done;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               start;
    logic               busy;
    logic               starve_hit;

    modport master (
        input  req, done,
        output gnt, gnt_idx, start, busy, starve_hit
    );

    modport slave (
        output req, done,
        input  gnt, gnt_idx, start, busy, starve_hit
    );

endinterface

// File: rtl/rand_arbiter_lfsr.sv
// Team Fibonacci LFSR: shifts left, feedback enters bit 0.
// Taps are bit0 ^ bit(N-1) for 2..4 bits and bit1 ^ bit4 for 5 bits.
//   clock  : posedge clock
//   reset  : synchronous, active-high; loads the value 1
//   enable : advance by one step this cycle, otherwise hold
//   value  : current LFSR contents
module rand_arbiter_lfsr #(
    parameter int NUM_BITS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    output logic [NUM_BITS-1:0] value
);

    logic feedback;

    generate
        if (NUM_BITS == 5) begin : g_taps_5
            assign feedback = value[1] ^ value[4];
        end else begin : g_taps_n
            assign feedback = value[0] ^ value[NUM_BITS-1];
        end
    endgenerate

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            value <= NUM_BITS'(1);
        end else if (enable) begin
            value <= {value[NUM_BITS-2:0], feedback};
        end
    end

endmodule

// File: rtl/rand_arbiter.sv
// Randomised arbiter with starvation protection.
// A decision is taken in any IDLE cycle with a pending request: the scan starts
// at (LFSR mod NUM_REQ) and wraps, unless some requester has lost STARVE_LIMIT
// decisions in a row, in which case the lowest such index is forced through.
//   clock : posedge clock
//   reset : synchronous, active-high
//   bus   : rand_arbiter_if master modport (req/done in; gnt, gnt_idx,
//           start, busy, starve_hit out)
module rand_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,   // power of two, 2..16
    parameter int LFSR_BITS    = 4,   // 2..5
    parameter int STARVE_LIMIT = 7    // 1..15
) (
    input  logic             clock,
    input  logic             reset,
    rand_arbiter_if.master   bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    arb_state_t           state;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 start_q;
    logic                 starve_q;
    logic [AGE_W-1:0]     age [NUM_REQ];

    logic [LFSR_BITS-1:0] lfsr_value;
    logic                 decide;
    logic [IDX_W-1:0]     scan_base;
    logic [IDX_W-1:0]     cand;
    logic                 found;
    logic [IDX_W-1:0]     win_idx;
    logic                 forced;

    assign decide = (state == IDLE) && (|bus.req);

    rand_arbiter_lfsr #(
        .NUM_BITS (LFSR_BITS)
    ) u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .enable (decide),
        .value  (lfsr_value)
    );

    // NUM_REQ is a power of two, so the modulo is a plain truncation and the
    // scan wraps naturally through IDX_W-bit overflow.
    assign scan_base = IDX_W'(32'(lfsr_value) % 32'(NUM_REQ));

    // NOTE: every variable written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cand    = '0;
        found   = 1'b0;
        win_idx = '0;
        forced  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = scan_base + IDX_W'(k);
            if (!found && bus.req[cand]) begin
                win_idx = cand;
                found   = 1'b1;
            end
        end
        // Descending walk so the lowest starved index is the last one written.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i] && (age[i] == AGE_MAX)) begin
                win_idx = IDX_W'(i);
                forced  = 1'b1;
            end
        end
    end

    // Age counters only move in IDLE: idle requesters and the winner clear,
    // losing requesters count up and saturate at the limit.
    // NOTE: the age array is a handful of per-requester registers, not a RAM,
    // so it is cleared element by element on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                age[i] <= '0;
            end
        end else if (state == IDLE) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!bus.req[i] || (IDX_W'(i) == win_idx)) begin
                    age[i] <= '0;
                end else if (age[i] != AGE_MAX) begin
                    age[i] <= age[i] + AGE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            gnt_q    <= '0;
            idx_q    <= '0;
            start_q  <= 1'b0;
            starve_q <= 1'b0;
        end else begin
            start_q  <= 1'b0;
            starve_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (decide) begin
                        gnt_q    <= NUM_REQ'(1) << win_idx;
                        idx_q    <= win_idx;
                        start_q  <= 1'b1;
                        starve_q <= forced;
                        state    <= START;
                    end else begin
                        gnt_q <= '0;
                        idx_q <= '0;
                    end
                end
                START, WAIT: begin
                    // req is deliberately ignored here: the grant is locked in
                    // until the resource signals done.
                    if (bus.done) begin
                        gnt_q <= '0;
                        idx_q <= '0;
                        state <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end
                default: begin
                    gnt_q <= '0;
                    idx_q <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.gnt_idx    = idx_q;
    assign bus.start      = start_q;
    assign bus.starve_hit = starve_q;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_rand_arbiter.sv
// Self-checking bench for rand_arbiter (NUM_REQ=4, LFSR_BITS=4, STARVE_LIMIT=2).
// A directed vector table from reset, a hand-written back-to-back sequence,
// then randomised traffic compared with a transaction-level reference model.
module tb_rand_arbiter;

    localparam int N     = 4;
    localparam int LIMIT = 2;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    rand_arbiter_if #(.NUM_REQ(N)) bus ();

    rand_arbiter #(
        .NUM_REQ      (N),
        .LFSR_BITS    (4),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks "is a transaction open", "is this its first cycle", which index
    // owns it, each requester's lost-decision count and the LFSR value.
    int m_lfsr;
    int m_age [N];
    bit m_open;
    bit m_first;
    bit m_forced;
    int m_win;

    function automatic int lfsr_next(input int v);
        return ((v << 1) & 15) | ((v & 1) ^ ((v >> 3) & 1));
    endfunction

    task automatic model_step(input bit r, input logic [N-1:0] q, input bit d);
        int w;
        if (r) begin
            m_open = 0; m_first = 0; m_forced = 0; m_win = 0; m_lfsr = 1;
            for (int i = 0; i < N; i++) m_age[i] = 0;
        end else if (!m_open) begin
            if (q == '0) begin
                for (int i = 0; i < N; i++) m_age[i] = 0;
            end else begin
                w = -1;
                for (int i = 0; i < N; i++)
                    if (w < 0 && q[i] && m_age[i] == LIMIT) w = i;
                m_forced = (w >= 0);
                if (w < 0)
                    for (int k = 0; k < N; k++)
                        if (w < 0 && q[(m_lfsr + k) % N]) w = (m_lfsr + k) % N;
                for (int i = 0; i < N; i++) begin
                    if (!q[i] || i == w) m_age[i] = 0;
                    else if (m_age[i] < LIMIT) m_age[i] = m_age[i] + 1;
                end
                m_lfsr  = lfsr_next(m_lfsr);
                m_win   = w;
                m_open  = 1;
                m_first = 1;
            end
        end else begin
            m_first = 0;
            if (d) m_open = 0;
        end
    endtask

    // One clock: the model sees the same inputs the DUT samples at the edge;
    // outputs are then read 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        model_step(reset, bus.req, bus.done);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_gnt"},    int'(bus.gnt),        m_open ? (1 << m_win) : 0);
        check({tag, "_idx"},    int'(bus.gnt_idx),    m_open ? m_win : 0);
        check({tag, "_start"},  int'(bus.start),      int'(m_open && m_first));
        check({tag, "_busy"},   int'(bus.busy),       int'(m_open));
        check({tag, "_starve"}, int'(bus.starve_hit), int'(m_open && m_first && m_forced));
        check({tag, "_onehot"}, int'($onehot0(bus.gnt)), 1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic         done;
        logic [N-1:0] gnt;
        logic [1:0]   idx;
        logic         start;
        logic         busy;
        logic         sh;
    } vec_t;

    vec_t vecs [25];

    function automatic vec_t mk(input logic rst, input logic [N-1:0] req, input logic done,
                                input logic [N-1:0] gnt, input logic [1:0] idx,
                                input logic start, input logic busy, input logic sh);
        vec_t v;
        v.rst = rst; v.req = req; v.done = done; v.gnt = gnt;
        v.idx = idx; v.start = start; v.busy = busy; v.sh = sh;
        return v;
    endfunction

    initial begin
        reset    = 1'b1;
        bus.req  = '0;
        bus.done = 1'b0;

        //               rst  req      done  gnt      idx  st   busy sh
        vecs[0]  = mk(1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0); // reset state
        vecs[1]  = mk(0, 4'b1111, 0, 4'b0010, 1, 1, 1, 0); // LFSR=1 -> req1
        vecs[2]  = mk(0, 4'b1111, 0, 4'b0010, 1, 0, 1, 0); // WAIT holds
        vecs[3]  = mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0, 0); // done -> IDLE
        vecs[4]  = mk(0, 4'b1111, 0, 4'b1000, 3, 1, 1, 0); // LFSR=3 -> req3
        vecs[5]  = mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0, 0); // done in START
        vecs[6]  = mk(0, 4'b1111, 0, 4'b0001, 0, 1, 1, 1); // req0 starved
        vecs[7]  = mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0, 0);
        vecs[8]  = mk(0, 4'b1111, 0, 4'b0010, 1, 1, 1, 1); // req1 starved
        vecs[9]  = mk(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
        vecs[10] = mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0); // idle, ages clear
        vecs[11] = mk(0, 4'b0100, 0, 4'b0100, 2, 1, 1, 0); // single req2
        vecs[12] = mk(0, 4'b0100, 0, 4'b0100, 2, 0, 1, 0);
        vecs[13] = mk(0, 4'b0000, 0, 4'b0100, 2, 0, 1, 0); // holder drops req
        vecs[14] = mk(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0); // done 3 cycles on
        vecs[15] = mk(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0); // done in IDLE
        vecs[16] = mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
        vecs[17] = mk(0, 4'b1000, 0, 4'b1000, 3, 1, 1, 0); // LFSR=13, wraps to 3
        vecs[18] = mk(0, 4'b1000, 0, 4'b1000, 3, 0, 1, 0); // WAIT
        vecs[19] = mk(1, 4'b1000, 0, 4'b0000, 0, 0, 0, 0); // reset in WAIT
        vecs[20] = mk(0, 4'b1111, 0, 4'b0010, 1, 1, 1, 0); // LFSR back to 1
        vecs[21] = mk(0, 4'b1111, 1, 4'b0000, 0, 0, 0, 0); // done in START
        vecs[22] = mk(0, 4'b1111, 0, 4'b1000, 3, 1, 1, 0); // LFSR=3
        vecs[23] = mk(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
        vecs[24] = mk(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);

        for (int v = 0; v < 25; v++) begin
            reset    = vecs[v].rst;
            bus.req  = vecs[v].req;
            bus.done = vecs[v].done;
            tick();
            check($sformatf("vec%0d_gnt", v),    int'(bus.gnt),        int'(vecs[v].gnt));
            check($sformatf("vec%0d_idx", v),    int'(bus.gnt_idx),    int'(vecs[v].idx));
            check($sformatf("vec%0d_start", v),  int'(bus.start),      int'(vecs[v].start));
            check($sformatf("vec%0d_busy", v),   int'(bus.busy),       int'(vecs[v].busy));
            check($sformatf("vec%0d_starve", v), int'(bus.starve_hit), int'(vecs[v].sh));
        end

        // ---------------- back-to-back sequence ----------------
        // done at cycle t -> decision at t+1 -> start visible at t+2.
        bus.req = 4'b0001; bus.done = 1'b0;
        tick();
        check("b2b_first_start", int'(bus.start), 1);
        check("b2b_first_gnt",   int'(bus.gnt),   1);
        bus.done = 1'b1;
        tick();
        check("b2b_idle_busy",   int'(bus.busy),  0);
        check("b2b_idle_gnt",    int'(bus.gnt),   0);
        check("b2b_idle_start",  int'(bus.start), 0);
        bus.done = 1'b0;
        tick();
        check("b2b_second_start", int'(bus.start), 1);
        check("b2b_second_gnt",   int'(bus.gnt),   1);
        tick();
        check("b2b_second_hold",  int'(bus.start), 0);
        bus.done = 1'b1; bus.req = '0;
        tick();
        check("b2b_end_busy",     int'(bus.busy),  0);
        bus.done = 1'b0;

        // ---------------- randomised traffic vs model ----------------
        reset = 1'b1;
        tick();
        check_model("rnd_reset");
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 149) == 0);
            case ($urandom_range(0, 3))
                0:       bus.req = '0;
                1:       bus.req = N'(1) << $urandom_range(0, N - 1);
                default: bus.req = N'($urandom);
            endcase
            bus.done = ($urandom_range(0, 2) == 0);
            tick();
            check_model("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
